wbm_cmd_bridge: RTL and testbench

- Wishbone classic single-transfer master. It is the initiator counterpart to the multiplexer's Wishbone slave port.
- Converts a valid/ready command stream into one Wishbone read or write cycle, then returns the result on a valid/ready response stream.
- A bus timeout prevents hangs when no slave acks.
- Used by the bring-up/debug front end and by the testbench to drive the project-select and custom-settings registers without the management SoC.

---
 rtl/wbm_pkg.sv | 18 +
 rtl/wbm_timeout_ctr.sv | 35 +++
 rtl/wbm_cmd_bridge.sv | 136 +++++++++++++
 tb/tb_wbm_cmd_bridge.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbm_pkg.sv
// Shared types and constants for the Wishbone command bridge.
// Holds the bridge state encoding, bus widths and the default timeout values.
package wbm_pkg;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    localparam int               DEF_TIMEOUT = 16;
    localparam logic [DAT_W-1:0] DEF_TO_DATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wbm_state_t;

endpackage

// File: rtl/wbm_timeout_ctr.sv
// Bus timeout counter for the Wishbone command bridge.
// Counts stb cycles without a termination.
// Raises expired once TIMEOUT-1 such cycles have elapsed.
// Saturates at that value instead of wrapping.
module wbm_timeout_ctr
    import wbm_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int             CW   = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    assign expired = (count == LAST);

    // Clear on a new cycle, otherwise count unterminated stb cycles up to LAST and hold there
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/wbm_cmd_bridge.sv
// Wishbone classic single-transfer master.
// Turns a valid/ready command into one read or write cycle on the bus.
// Returns the result on a valid/ready response stream.
// A bus timeout aborts cycles that no slave acknowledges.
// Optional feature macro WBM_CMD_BRIDGE_ERR_EN:
//   - adds wbm_err_i, which terminates a cycle with rsp_err=1 and rsp_dat=0;
//   - wbm_err_i takes priority over wbm_ack_i.
module wbm_cmd_bridge
    import wbm_pkg::*;
#(
    parameter int               TIMEOUT = DEF_TIMEOUT,
    parameter logic [DAT_W-1:0] TO_DATA = DEF_TO_DATA
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [ADR_W-1:0] cmd_adr,
    input  logic [DAT_W-1:0] cmd_dat,
    input  logic [SEL_W-1:0] cmd_sel,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DAT_W-1:0] rsp_dat,
    output logic             rsp_err,

    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [SEL_W-1:0] wbm_sel_o,
    output logic [ADR_W-1:0] wbm_adr_o,
    output logic [DAT_W-1:0] wbm_dat_o,
    input  logic             wbm_ack_i,
`ifdef WBM_CMD_BRIDGE_ERR_EN
    input  logic             wbm_err_i,
`endif
    input  logic [DAT_W-1:0] wbm_dat_i
);

    wbm_state_t state;
    logic       bus_err;
    logic       to_clear;
    logic       to_enable;
    logic       to_expired;

`ifdef WBM_CMD_BRIDGE_ERR_EN
    assign bus_err = wbm_err_i;
`else
    assign bus_err = 1'b0;
`endif

    // The counter restarts on command acceptance.
    // It advances on every bus cycle that ends without a termination.
    assign to_clear  = (state == IDLE) && cmd_valid && cmd_ready;
    assign to_enable = (state == BUS) && !wbm_ack_i && !bus_err;

    wbm_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clear   (to_clear),
        .enable  (to_enable),
        .expired (to_expired)
    );

    // Control FSM with all bus and stream outputs registered.
    // Termination priority in BUS: error, then ack, then timeout.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        wbm_we_o  <= cmd_we;
                        wbm_adr_o <= cmd_adr;
                        wbm_dat_o <= cmd_dat;
                        wbm_sel_o <= cmd_sel;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= BUS;
                    end
                end
                BUS: begin
                    if (bus_err) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_dat   <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_dat   <= wbm_we_o ? '0 : wbm_dat_i;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (to_expired) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_dat   <= TO_DATA;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wbm_cmd_bridge.sv
// Directed testbench for wbm_cmd_bridge.
// Expected responses are queued when a command is issued.
// A monitor compares them as the bridge hands each response over.
module tb_wbm_cmd_bridge;

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;
`ifdef WBM_CMD_BRIDGE_ERR_EN
    logic        wbm_err_i;
    logic        err_with_ack;
`endif

    typedef struct packed {
        logic        err;
        logic [31:0] dat;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_exp;
    int   checks = 0;
    int   errors = 0;

    wbm_cmd_bridge #(
        .TIMEOUT (16),
        .TO_DATA (32'hFFFF_FFFF)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_i (wbm_ack_i),
`ifdef WBM_CMD_BRIDGE_ERR_EN
        .wbm_err_i (wbm_err_i),
`endif
        .wbm_dat_i (wbm_dat_i)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Issue one command, act as the slave, and queue the expected response.
    // waits = wait states before ack; a negative value means never ack.
    task automatic applyStimulus(input string tag, input logic we, input logic [31:0] adr,
                                 input logic [31:0] dat, input logic [3:0] sel, input int waits,
                                 input logic [31:0] rdata, input int exp_stb,
                                 input logic [31:0] exp_dat, input logic exp_err);
        int   stb_cycles;
        logic stable;
        rsp_t e;
        checkOutput({tag, "_cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        e.err     = exp_err;
        e.dat     = exp_dat;
        exp_q.push_back(e);
        tick();
        cmd_valid = 1'b0;
        cmd_we    = ~we;
        cmd_adr   = ~adr;
        cmd_dat   = ~dat;
        cmd_sel   = ~sel;
        checkOutput({tag, "_cyc_stb"}, 32'({wbm_cyc_o, wbm_stb_o}), 32'd3);
        checkOutput({tag, "_adr"}, wbm_adr_o, adr);
        checkOutput({tag, "_dat_o"}, wbm_dat_o, dat);
        checkOutput({tag, "_we_sel"}, 32'({wbm_we_o, wbm_sel_o}), 32'({we, sel}));
        checkOutput({tag, "_cmd_ready_busy"}, 32'(cmd_ready), 32'd0);
        stb_cycles = 0;
        stable     = 1'b1;
        for (int i = 0; i < 40 && wbm_stb_o; i++) begin
            stb_cycles++;
            if (wbm_adr_o !== adr || wbm_dat_o !== dat || wbm_sel_o !== sel ||
                wbm_we_o !== we || wbm_cyc_o !== 1'b1)
                stable = 1'b0;
            if (stb_cycles == waits + 1) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = rdata;
`ifdef WBM_CMD_BRIDGE_ERR_EN
                wbm_err_i = err_with_ack;
`endif
            end
            tick();
            wbm_ack_i = 1'b0;
            wbm_dat_i = 32'hDEAD_BEEF;
`ifdef WBM_CMD_BRIDGE_ERR_EN
            wbm_err_i = 1'b0;
`endif
        end
        checkOutput({tag, "_stb_cycles"}, 32'(stb_cycles), 32'(exp_stb));
        checkOutput({tag, "_bus_stable"}, 32'(stable), 32'd1);
        checkOutput({tag, "_cyc_dropped"}, 32'(wbm_cyc_o), 32'd0);
        checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    endtask

    // Let the pending response drain and confirm the bridge is idle again.
    task automatic endResponse(input string tag);
        tick();
        checkOutput({tag, "_rsp_done"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, "_cmd_ready_back"}, 32'(cmd_ready), 32'd1);
    endtask

    // Response monitor: compare each accepted response with the head of the queue.
    always @(negedge wb_clk_i) begin
        if (!wb_rst_i && rsp_valid && rsp_ready) begin
            checkOutput("rsp_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                checkOutput("rsp_dat", rsp_dat, mon_exp.dat);
                checkOutput("rsp_err", 32'(rsp_err), 32'(mon_exp.err));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        wb_rst_i  = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        rsp_ready = 1'b1;
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'hDEAD_BEEF;
`ifdef WBM_CMD_BRIDGE_ERR_EN
        wbm_err_i    = 1'b0;
        err_with_ack = 1'b0;
`endif
        tick();
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
        checkOutput("rst_rsp_dat", rsp_dat, 32'd0);
        checkOutput("rst_bus_ctl", 32'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}), 32'd0);
        checkOutput("rst_adr", wbm_adr_o, 32'd0);
        checkOutput("rst_dat_o", wbm_dat_o, 32'd0);
        tick();
        wb_rst_i = 1'b0;
        tick();

        $display("[TB] spurious ack in IDLE");
        wbm_ack_i = 1'b1;
        tick();
        tick();
        wbm_ack_i = 1'b0;
        checkOutput("idle_ack_cyc", 32'(wbm_cyc_o), 32'd0);
        checkOutput("idle_ack_rsp", 32'(rsp_valid), 32'd0);

        $display("[TB] zero-wait write");
        applyStimulus("wr0", 1'b1, 32'h3000_0000, 32'h0000_0005, 4'hF, 0, 32'h5555_AAAA,
                      1, 32'h0000_0000, 1'b0);
        endResponse("wr0");

        $display("[TB] read with 3 wait states");
        applyStimulus("rd3", 1'b0, 32'h3000_0004, 32'h0000_0000, 4'h3, 3, 32'hA5A5_1234,
                      4, 32'hA5A5_1234, 1'b0);
        endResponse("rd3");

        $display("[TB] timeout");
        applyStimulus("to", 1'b0, 32'h3000_0008, 32'h0000_0000, 4'hF, -1, 32'h0,
                      16, 32'hFFFF_FFFF, 1'b1);
        endResponse("to");

        $display("[TB] ack on expiry cycle");
        applyStimulus("ackexp", 1'b0, 32'h3000_000C, 32'h0000_0000, 4'h1, 15, 32'h0000_0001,
                      16, 32'h0000_0001, 1'b0);
        endResponse("ackexp");

        $display("[TB] response backpressure");
        rsp_ready = 1'b0;
        applyStimulus("bp", 1'b0, 32'h3000_0010, 32'h0000_0000, 4'hC, 0, 32'h1234_5678,
                      1, 32'h1234_5678, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1;
            cmd_we    = 1'b1;
            cmd_adr   = 32'h3000_0020;
            wbm_ack_i = 1'b1;
            tick();
            checkOutput("bp_rsp_held", 32'({rsp_valid, rsp_err}), 32'd2);
            checkOutput("bp_rsp_dat", rsp_dat, 32'h1234_5678);
            checkOutput("bp_no_accept", 32'({cmd_ready, wbm_cyc_o, wbm_stb_o}), 32'd0);
        end
        wbm_ack_i = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        endResponse("bp");
        checkOutput("bp_no_second_cycle", 32'(wbm_cyc_o), 32'd0);

        $display("[TB] reset mid-operation");
        checkOutput("mid_queue_empty", 32'(exp_q.size()), 32'd0);
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h3000_0030;
        tick();
        cmd_valid = 1'b0;
        tick();
        checkOutput("mid_in_bus", 32'({wbm_cyc_o, wbm_stb_o}), 32'd3);
        wb_rst_i = 1'b1;
        #1;
        checkOutput("mid_async_drop", 32'({wbm_cyc_o, wbm_stb_o}), 32'd0);
        tick();
        wb_rst_i = 1'b0;
        tick();
        tick();
        checkOutput("mid_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("mid_no_rsp", 32'(rsp_valid), 32'd0);

        $display("[TB] transfer after reset");
        applyStimulus("post", 1'b0, 32'h3000_0040, 32'h0000_0000, 4'hF, 1, 32'hCAFE_0042,
                      2, 32'hCAFE_0042, 1'b0);
        endResponse("post");

`ifdef WBM_CMD_BRIDGE_ERR_EN
        $display("[TB] err together with ack");
        err_with_ack = 1'b1;
        applyStimulus("err", 1'b0, 32'h3000_0050, 32'h0000_0000, 4'hF, 1, 32'h7777_7777,
                      2, 32'h0000_0000, 1'b1);
        endResponse("err");
        err_with_ack = 1'b0;
`endif

        checkOutput("all_rsp_seen", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
